addsub_serial: RTL and testbench

Parametrised, digit-serial signed adder/subtractor with valid/ready handshakes on input and output. It processes DIGIT bits per clock from LSB upward and produces an exact WIDTH+1-bit two's-complement result, a WIDTH-bit signed overflow flag and a zero flag. It is the multi-cycle, area-reduced arithmetic unit for the ALU datapath, for wide operands where a full-width combinational subtractor is too large or too slow.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_digit.sv | 25 ++
 rtl/addsub_serial.sv | 123 ++++++++++++
 tb/tb_addsub_serial.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial signed adder/subtractor.
// FSM state encoding, op codes and the signed-overflow decode.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } addsub_state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Exact result disagrees with its WIDTH-bit truncation when the top two bits differ.
   function automatic logic ovf_signed(input logic msb_ext, input logic msb);
      return msb_ext ^ msb;
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice, reused every cycle by the serial unit.
// Zero latency; no handshake, purely combinational.
module addsub_digit #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);

   logic c;

   always_comb begin
      c   = cin;
      sum = '0;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i] = x[i] ^ y[i] ^ c;
         c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial signed add/sub producing an exact WIDTH+1-bit result; latency WIDTH/DIGIT cycles.
// Accepts only in IDLE; out_ready low holds DONE and all outputs stable indefinitely.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("addsub_serial: illegal WIDTH/DIGIT combination");
   end

   addsub_state_e    state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   res_q;
   logic             ovf_q, zero_q;

   logic [DIGIT-1:0] dsum;
   logic             dcout;
   logic             last_digit;
   logic [WIDTH-1:0] res_lo_next;
   logic [WIDTH:0]   res_next;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x    (a_sh[DIGIT-1:0]),
      .y    (b_sh[DIGIT-1:0]),
      .cin  (carry_q),
      .sum  (dsum),
      .cout (dcout)
   );

   assign last_digit = (cnt_q == CW'(N - 1));

   // Operands shift down so the current digit is always at the bottom; result bits
   // shift in from the top, so after N digits digit k sits at [k*DIGIT +: DIGIT].
   assign res_lo_next = (res_q[WIDTH-1:0] >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
   // On the last digit the bottom of a_sh/b_sh holds the operand sign bits.
   assign res_next    = {a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dcout, res_lo_next};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = BUSY;
         end
         BUSY: begin
            if (last_digit) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a;
                  b_sh    <= (op == OP_SUB) ? ~b : b;
                  carry_q <= (op == OP_SUB);
                  cnt_q   <= '0;
               end
            end
            BUSY: begin
               a_sh    <= a_sh >> DIGIT;
               b_sh    <= b_sh >> DIGIT;
               carry_q <= dcout;
               cnt_q   <= cnt_q + CW'(1);
               res_q   <= res_next;
               if (last_digit) begin
                  ovf_q  <= ovf_signed(res_next[WIDTH], res_next[WIDTH-1]);
                  zero_q <= (res_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign result   = res_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=8, DIGIT=2): vector table, corner sequences, random sweep.
module tb_addsub_serial;

   localparam int WIDTH = 8;
   localparam int DIGIT = 2;
   localparam int N     = WIDTH / DIGIT;

   typedef struct {
      logic [8:0] res;
      logic       ovf;
      logic       zero;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      logic [8:0] res;
      logic       ovf;
      logic       zero;
   } vec_t;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a_in      = '0;
   logic [WIDTH-1:0] b_in      = '0;
   logic             op_in     = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH:0]   result;
   logic             overflow;
   logic             zero;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_in),
      .b         (b_in),
      .op        (op_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic op);
      exp_t e;
      logic signed [8:0] ea, eb, r;
      ea = $signed({a[7], a});
      eb = $signed({b[7], b});
      r  = op ? (ea - eb) : (ea + eb);
      e.res  = r;
      e.ovf  = r[8] ^ r[7];
      e.zero = (r == 9'sd0);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents operands until accepted; pushes the expected outcome on the accept edge.
   task automatic drive_accept(input logic [7:0] a, input logic [7:0] b, input logic op,
                               input exp_t e, output int waited);
      a_in     = a;
      b_in     = b;
      op_in    = op;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         step();
         waited++;
      end
      check("accept_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
   endtask

   // Waits for out_valid, checks latency and outputs, optionally stalls, then completes the handshake.
   task automatic collect(input string tag, input int hold);
      int   lat;
      exp_t e;
      lat       = 0;
      out_ready = (hold == 0);
      while (!out_valid && lat < 4 * N + 10) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(N));
      check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_result"}, 32'(result), 32'(e.res));
         check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
         check({tag, "_zero"}, 32'(zero), 32'(e.zero));
         for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_result"}, 32'({result, overflow, zero}), 32'({e.res, e.ovf, e.zero}));
         end
      end
      out_ready = 1'b1;
      step();
      check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      vec_t       vecs[10];
      exp_t       e;
      int         waited;
      logic [7:0] ra, rb;
      logic       rop;
      logic [7:0] corners[5];

      vecs[0] = '{8'h05, 8'h03, 1'b1, 9'h002, 1'b0, 1'b0};
      vecs[1] = '{8'h80, 8'h01, 1'b1, 9'h17F, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 1'b0};
      vecs[3] = '{8'h80, 8'h80, 1'b1, 9'h000, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 8'h01, 1'b0, 9'h000, 1'b0, 1'b1};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 1'b0};
      vecs[6] = '{8'h80, 8'h7F, 1'b1, 9'h101, 1'b1, 1'b0};
      vecs[7] = '{8'h7F, 8'h80, 1'b1, 9'h0FF, 1'b1, 1'b0};
      vecs[8] = '{8'h03, 8'hFC, 1'b0, 9'h1FF, 1'b0, 1'b0};
      vecs[9] = '{8'h00, 8'h80, 1'b1, 9'h080, 1'b1, 1'b0};
      corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

      // Reset state
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         e.res  = vecs[i].res;
         e.ovf  = vecs[i].ovf;
         e.zero = vecs[i].zero;
         drive_accept(vecs[i].a, vecs[i].b, vecs[i].op, e, waited);
         check("vec_busy_in_ready", 32'(in_ready), 32'd0);
         collect($sformatf("vec%0d", i), 0);
      end

      // Backpressure: new operands wait at in_valid until one cycle after the result handshake
      e = '{9'h002, 1'b0, 1'b0};
      drive_accept(8'h05, 8'h03, 1'b1, e, waited);
      a_in     = 8'h11;
      b_in     = 8'h22;
      op_in    = 1'b0;
      in_valid = 1'b1;
      collect("bp", 5);
      drive_accept(8'h11, 8'h22, 1'b0, '{9'h033, 1'b0, 1'b0}, waited);
      check("bp_accept_wait", 32'(waited), 32'd0);
      check("bp_busy_in_ready", 32'(in_ready), 32'd0);
      collect("bp_next", 0);

      // Reset in the middle of an operation discards it
      drive_accept(8'h05, 8'h03, 1'b1, '{9'h002, 1'b0, 1'b0}, waited);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < N + 2; i++) begin
         step();
         check("midrst_no_output", 32'(out_valid), 32'd0);
      end
      drive_accept(8'h00, 8'h80, 1'b1, '{9'h080, 1'b1, 1'b0}, waited);
      collect("midrst_next", 0);

      // Random sweep against the arithmetic reference model
      for (int i = 0; i < 1500; i++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rop = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 4)];
         e = model(ra, rb, rop);
         drive_accept(ra, rb, rop, e, waited);
         collect("rnd", int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
